// File: rtl/semaforo_pkg.sv
// Shared definitions for the semaforo input path: debounce FSM encoding and
// tick constants for the 10 kHz LF clock.
package semaforo_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StPressed     = 2'd2,
        StReleaseWait = 2'd3
    } deb_state_e;

    localparam int unsigned DEB_20MS = 200;
    localparam int unsigned LONG_2S  = 20000;

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input channel: 2-FF synchronizer, debounce FSM with
// registered level/press/release/long-press outputs.
module debounce_channel
    import semaforo_pkg::*;
#(
    parameter int unsigned DEB_TICKS  = DEB_20MS,
    parameter int unsigned LONG_TICKS = LONG_2S
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic press_p,
    output logic release_p,
    output logic long_p
);

    localparam int unsigned DW = $clog2(DEB_TICKS);
    localparam int unsigned LW = $clog2(LONG_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_TICKS);
    localparam logic [LW-1:0] LONG_PRE  = LW'(LONG_TICKS - 1);

    if (DEB_TICKS < 2 || LONG_TICKS <= DEB_TICKS) begin : g_bad_params
        $error("debounce_channel: need DEB_TICKS >= 2 and LONG_TICKS > DEB_TICKS");
    end

    logic          sync1;
    logic          sync2;
    deb_state_e    state;
    logic [DW-1:0] dcnt;
    logic [LW-1:0] lcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            state     <= StIdle;
            dcnt      <= '0;
            lcnt      <= '0;
            level     <= 1'b0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            long_p    <= 1'b0;
        end else begin
            sync1     <= din;
            sync2     <= sync1;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            long_p    <= 1'b0;
            unique case (state)
                StIdle: begin
                    level <= 1'b0;
                    lcnt  <= '0;
                    if (sync2) begin
                        state <= StPressWait;
                        dcnt  <= DW'(1);
                    end else begin
                        dcnt  <= '0;
                    end
                end
                StPressWait: begin
                    if (!sync2) begin
                        state <= StIdle;
                        dcnt  <= '0;
                    end else if (dcnt == DEB_LAST) begin
                        state   <= StPressed;
                        level   <= 1'b1;
                        press_p <= 1'b1;
                        dcnt    <= '0;
                        lcnt    <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                StPressed: begin
                    // Saturating long count; the single step into LONG_MAX is the pulse.
                    if (lcnt != LONG_MAX) begin
                        lcnt   <= lcnt + 1'b1;
                        long_p <= (lcnt == LONG_PRE);
                    end
                    if (!sync2) begin
                        state <= StReleaseWait;
                        dcnt  <= DW'(1);
                    end
                end
                StReleaseWait: begin
                    // Long count is held here so release chatter cannot discard it.
                    if (sync2) begin
                        state <= StPressed;
                        dcnt  <= '0;
                    end else if (dcnt == DEB_LAST) begin
                        state     <= StIdle;
                        level     <= 1'b0;
                        release_p <= 1'b1;
                        dcnt      <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw GPIO buttons for semaforo: polarity normalization followed by
// one independent debounce_channel per input.
module button_conditioner
    import semaforo_pkg::*;
#(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned DEB_TICKS  = DEB_20MS,
    parameter int unsigned LONG_TICKS = LONG_2S,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_p,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] long_p
);

    logic [N_CH-1:0] pressed_raw;

    assign pressed_raw = (ACTIVE_LOW != 0) ? ~raw_in : raw_in;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEB_TICKS  (DEB_TICKS),
            .LONG_TICKS (LONG_TICKS)
        ) u_ch (
            .clk       (CLK),
            .rst_n     (reset),
            .din       (pressed_raw[i]),
            .level     (level[i]),
            .press_p   (press_p[i]),
            .release_p (release_p[i]),
            .long_p    (long_p[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: expected pulse events are queued
// with their due cycle when stimulus is driven and compared every cycle.
`timescale 1ns/1ps
module tb_button_conditioner;

    localparam int N    = 3;
    localparam int DEB  = 200;
    localparam int LONG = 20000;
    localparam int LAT  = DEB + 2;

    localparam int KPress   = 0;
    localparam int KRelease = 1;
    localparam int KLong    = 2;

    logic         CLK = 1'b0;
    logic         reset;
    logic [N-1:0] pressed;
    logic [N-1:0] raw_in;
    logic [N-1:0] level, press_p, release_p, long_p;

    assign raw_in = ~pressed;

    button_conditioner dut (
        .CLK       (CLK),
        .reset     (reset),
        .raw_in    (raw_in),
        .level     (level),
        .press_p   (press_p),
        .release_p (release_p),
        .long_p    (long_p)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned cyc;
        int          ch;
        int          kind;
    } ev_t;

    typedef struct {
        int ch;
        int hold;
        int gap;
        bit exp_press;
        bit exp_long;
    } vec_t;

    ev_t          sb[$];
    int unsigned  cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] exp_level = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {20'd0, level, press_p, release_p, long_p};
    endfunction

    task automatic push(input int unsigned c, input int ch, input int kind);
        sb.push_back('{cyc: c, ch: ch, kind: kind});
    endtask

    // Inputs always change 2 time units after a rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // Per-cycle monitor: {level, press_p, release_p, long_p} against the queue.
    logic [N-1:0] ep, er, el;
    always @(negedge CLK) begin
        ep = '0;
        er = '0;
        el = '0;
        if (!reset) begin
            exp_level = '0;
            sb.delete();
        end else begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    case (sb[i].kind)
                        KPress:   ep[sb[i].ch] = 1'b1;
                        KRelease: er[sb[i].ch] = 1'b1;
                        default:  el[sb[i].ch] = 1'b1;
                    endcase
                    sb.delete(i);
                end
            end
            exp_level = (exp_level | ep) & ~er;
        end
        check("lvl_press_rel_long", outs(), {20'd0, exp_level, ep, er, el});
    end

    vec_t vecs[6];
    int unsigned t0;

    initial begin
        vecs[0] = '{ch: 1, hold: 1000,  gap: 400, exp_press: 1'b1, exp_long: 1'b0};
        vecs[1] = '{ch: 0, hold: 199,   gap: 300, exp_press: 1'b0, exp_long: 1'b0};
        vecs[2] = '{ch: 0, hold: 200,   gap: 400, exp_press: 1'b1, exp_long: 1'b0};
        vecs[3] = '{ch: 2, hold: 2,     gap: 300, exp_press: 1'b0, exp_long: 1'b0};
        vecs[4] = '{ch: 2, hold: 25000, gap: 400, exp_press: 1'b1, exp_long: 1'b1};
        vecs[5] = '{ch: 1, hold: 300,   gap: 400, exp_press: 1'b1, exp_long: 1'b0};

        // Reset held with raw inputs toggling; release with ch0 held.
        reset   = 1'b0;
        pressed = '0;
        #1;
        check("reset_state", outs(), 32'd0);
        for (int i = 0; i < 40; i++) begin
            wait_cycles(1);
            pressed = N'($urandom);
        end
        check("reset_hold", outs(), 32'd0);
        pressed = 3'b001;
        wait_cycles(1);
        reset = 1'b1;
        t0 = cyc;
        push(t0 + LAT, 0, KPress);
        wait_cycles(600);
        pressed[0] = 1'b0;
        push(cyc + LAT, 0, KRelease);
        wait_cycles(400);

        // Table of single presses: duration vs. expected pulses.
        for (int v = 0; v < 6; v++) begin
            t0 = cyc;
            pressed[vecs[v].ch] = 1'b1;
            if (vecs[v].exp_press) push(t0 + LAT, vecs[v].ch, KPress);
            if (vecs[v].exp_long) push(t0 + LAT + LONG, vecs[v].ch, KLong);
            wait_cycles(vecs[v].hold);
            pressed[vecs[v].ch] = 1'b0;
            if (vecs[v].exp_press) push(cyc + LAT, vecs[v].ch, KRelease);
            wait_cycles(vecs[v].gap);
        end

        // Bounce: ch0 toggles every 50 cycles, never stable long enough.
        for (int i = 0; i < 10; i++) begin
            pressed[0] = ~pressed[0];
            wait_cycles(50);
        end
        wait_cycles(300);

        // Release chatter on ch1: three 100-cycle glitches; long count held meanwhile.
        t0 = cyc;
        pressed[1] = 1'b1;
        push(t0 + LAT, 1, KPress);
        push(t0 + LAT + LONG + 3 * 100, 1, KLong);
        wait_cycles(500);
        for (int g = 0; g < 3; g++) begin
            pressed[1] = 1'b0;
            wait_cycles(100);
            pressed[1] = 1'b1;
            wait_cycles(400);
        end
        wait_cycles(19500);
        pressed[1] = 1'b0;
        push(cyc + LAT, 1, KRelease);
        wait_cycles(400);

        // Parallel press on ch0/ch1, then asynchronous reset mid-press.
        t0 = cyc;
        pressed = 3'b011;
        push(t0 + LAT, 0, KPress);
        push(t0 + LAT, 1, KPress);
        wait_cycles(500);
        check("level_before_reset", {29'd0, level}, 32'd3);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 32'd0);
        sb.delete();
        wait_cycles(10);
        reset = 1'b1;
        t0 = cyc;
        push(t0 + LAT, 0, KPress);
        push(t0 + LAT, 1, KPress);
        wait_cycles(400);
        pressed = '0;
        push(cyc + LAT, 0, KRelease);
        push(cyc + LAT, 1, KRelease);
        wait_cycles(400);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
